stream_capture_ctrl: RTL and testbench
======================================

// Module: stream_capture_ctrl
// PURPOSE
//  Sequences the serial-in -> 16-bit FIFO -> okPipeOut (A0) capture path under host control.
//  Host start/stop come from okTriggerIn bits; limit comes from okWireIn; status goes to okWireOut.
//  Deserialises serial_in, gates FIFO writes on fifo_full, flushes the FIFO on start and counts dropped words.
//  Replaces the free-running 4-bit cycle counter and ungated wr_en in the top level.
// PARAMETERS
//  DATA_W        16       FIFO word width; one word = DATA_W serial bits
//  CNT_W         16       width of word_count / drop_count
//  FLUSH_CYCLES  8        cycles fifo_rst is held high on start (>=1)
//  SYNC_WORD     16'hA55A alignment pattern; used only with STREAM_SYNC_HUNT_EN
// PORTS
//  ti_clk          in   1       host interface clock; single clock domain
//  reset           in   1       asynchronous, active-high; wire-in bit 0
//  serial_in       in   1       serial data; sampled every ti_clk rising edge
//  cmd_start       in   1       1-cycle trigger pulse: flush + begin capture
//  cmd_stop        in   1       1-cycle trigger pulse: end capture
//  cfg_word_limit  in   CNT_W   words to capture; 0 = unlimited
//  fifo_full       in   1       FIFO full flag
//  fifo_rst        out  1       FIFO reset
//  fifo_wr_en      out  1       FIFO write strobe, 1-cycle pulse
//  fifo_din        out  DATA_W  FIFO write data, valid when fifo_wr_en=1
//  word_count      out  CNT_W   words written this capture (saturating)
//  drop_count      out  CNT_W   words dropped on fifo_full this capture (saturating)
//  state           out  2       0=IDLE 1=FLUSH 2=CAPTURE 3=DONE
//  busy            out  1       1 in FLUSH or CAPTURE
// BEHAVIOUR
//  Reset (async): state=IDLE, all outputs 0, shift register and bit counter 0.
//  IDLE: serial_in ignored. cmd_start -> FLUSH; clear word_count and drop_count; latch cfg_word_limit.
//  FLUSH: fifo_rst=1 for exactly FLUSH_CYCLES cycles, then fifo_rst=0 and go to CAPTURE.
//    bit_cnt=0 on exit. cmd_stop during FLUSH -> DONE after the flush completes.
//  CAPTURE: every cycle shift <= {shift[DATA_W-2:0], serial_in}, MSB first; bit_cnt++.
//    Word complete on the cycle where bit_cnt==DATA_W-1; bit_cnt wraps to 0.
//    fifo_din and fifo_wr_en are registered: wr_en is high one cycle after the last bit is sampled.
//    Word complete and fifo_full=0: fifo_wr_en=1, word_count++.
//    Word complete and fifo_full=1: no write, drop_count++, word discarded.
//    fifo_full is sampled on the word-complete cycle.
//    Latched limit!=0 and the write that makes word_count==limit -> DONE, with that write still issued.
//    cmd_stop -> DONE next cycle; partial word discarded; a word completing on the same cycle is still written.
//    cmd_start in CAPTURE is ignored. cmd_start and cmd_stop together: stop wins.
//  DONE: holds counters; fifo_wr_en=0. cmd_start -> FLUSH (restart, counters cleared).
//  Counters saturate at all-ones; no wrap.
//  Latched limit is unaffected by cfg_word_limit changes mid-capture.
//  Reset mid-capture: immediate return to IDLE, counters cleared, fifo_rst not asserted by this block.
//  fifo_rst and fifo_wr_en are never high on the same cycle.
// CONFIGURATION
//  `STREAM_SYNC_HUNT_EN defined:
//    Adds a HUNT phase between FLUSH and CAPTURE; state reports 2 during HUNT.
//    In HUNT, shift runs each cycle; nothing is written.
//    When the shifted value == SYNC_WORD, go to CAPTURE with bit_cnt=0.
//    The sync word is not written. cmd_stop in HUNT -> DONE.
//  Not defined: FLUSH -> CAPTURE directly; SYNC_WORD unused; word boundaries are relative to end of flush.
// TESTING
//  1 reset=1 mid-CAPTURE -> state=0, word_count=0, drop_count=0, fifo_wr_en=0 the same cycle (async).
//  2 start, limit=3, serial stream of 16'h1234,16'hABCD,16'h0F0F,16'hFFFF
//      -> fifo_rst high 8 cycles; 3 writes 1234/ABCD/0F0F spaced 16 cycles apart;
//      -> state=3; word_count=3; 4th word not written.
//  3 limit=0, fifo_full=1 during 2nd word boundary -> word 2 dropped; drop_count=1; words 1,3 written.
//  4 cmd_stop 5 bits into word 4 -> DONE; word_count=3; no partial write.
//    cmd_start+cmd_stop same cycle in CAPTURE -> DONE.
//  5 limit=0 with fifo_full stuck 1 for 2^16+2 words -> drop_count=16'hFFFF (saturates), word_count=0.
//  6 (STREAM_SYNC_HUNT_EN) noise, then A55A, then 16'h0001 -> first write 0001; A55A is not written.

Source files
------------

// File: rtl/stream_capture_ctrl.sv
// Host-controlled capture sequencer: flush FIFO, deserialise serial_in MSB-first, gate writes on fifo_full.
// Optional sync-word hunt before capture is enabled by defining STREAM_SYNC_HUNT_EN.
module stream_capture_ctrl #(
    parameter int                DATA_W       = 16,
    parameter int                CNT_W        = 16,
    parameter int                FLUSH_CYCLES = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD    = 16'hA55A
) (
    input  logic              ti_clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic [CNT_W-1:0]  cfg_word_limit,
    input  logic              fifo_full,
    output logic              fifo_rst,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic [1:0]        state,
    output logic              busy
);

    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
    localparam int BC_W = (DATA_W < 2) ? 1 : $clog2(DATA_W);

    // HUNT shares the low two bits with CAPTURE so the host sees state=2 in both.
    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FLUSH   = 3'b001,
        S_CAPTURE = 3'b010,
        S_DONE    = 3'b011,
        S_HUNT    = 3'b110
    } st_t;

    st_t               st;
    logic [DATA_W-1:0] shift_q;
    logic [BC_W-1:0]   bit_cnt;
    logic [FC_W-1:0]   flush_cnt;
    logic [CNT_W-1:0]  limit_q;
    logic              stop_pend;

    logic [DATA_W-1:0] word_next;
    logic              word_done;
    logic              flush_last;
    logic [CNT_W-1:0]  wc_inc;
    logic [CNT_W-1:0]  dc_inc;

    assign word_next  = {shift_q[DATA_W-2:0], serial_in};
    assign word_done  = (bit_cnt == BC_W'(DATA_W-1));
    assign flush_last = (flush_cnt == FC_W'(FLUSH_CYCLES-1));
    assign wc_inc     = (&word_count) ? word_count : word_count + 1'b1;
    assign dc_inc     = (&drop_count) ? drop_count : drop_count + 1'b1;

    assign state = st[1:0];
    assign busy  = (st == S_FLUSH) || (st == S_CAPTURE) || (st == S_HUNT);

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            st         <= S_IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            flush_cnt  <= '0;
            limit_q    <= '0;
            stop_pend  <= 1'b0;
            fifo_rst   <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            word_count <= '0;
            drop_count <= '0;
        end else begin
            fifo_wr_en <= 1'b0;
            case (st)
                S_IDLE, S_DONE: begin
                    if (cmd_start) begin
                        st         <= S_FLUSH;
                        fifo_rst   <= 1'b1;
                        flush_cnt  <= '0;
                        word_count <= '0;
                        drop_count <= '0;
                        limit_q    <= cfg_word_limit;
                        stop_pend  <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (cmd_stop)
                        stop_pend <= 1'b1;
                    if (flush_last) begin
                        fifo_rst <= 1'b0;
                        bit_cnt  <= '0;
                        shift_q  <= '0;
                        if (stop_pend || cmd_stop)
                            st <= S_DONE;
                        else
`ifdef STREAM_SYNC_HUNT_EN
                            st <= S_HUNT;
`else
                            st <= S_CAPTURE;
`endif
                    end
                end
                S_CAPTURE: begin
                    shift_q <= word_next;
                    bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                    if (word_done) begin
                        if (!fifo_full) begin
                            fifo_wr_en <= 1'b1;
                            fifo_din   <= word_next;
                            word_count <= wc_inc;
                            if ((limit_q != '0) && (wc_inc == limit_q))
                                st <= S_DONE;
                        end else begin
                            drop_count <= dc_inc;
                        end
                    end
                    // A word finishing on the stop cycle was already written above.
                    if (cmd_stop)
                        st <= S_DONE;
                end
`ifdef STREAM_SYNC_HUNT_EN
                S_HUNT: begin
                    shift_q <= word_next;
                    if (cmd_stop) begin
                        st <= S_DONE;
                    end else if (word_next == SYNC_WORD) begin
                        st      <= S_CAPTURE;
                        bit_cnt <= '0;
                    end
                end
`endif
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_capture_ctrl.sv
// Directed bench for stream_capture_ctrl: queue-based reference model checked every cycle plus literal pins.
// Counter width is reduced so the saturation case fits in a short run.
module tb_stream_capture_ctrl;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 6;
    localparam int FLUSH  = 8;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              ti_clk = 1'b0;
    logic              reset;
    logic              serial_in;
    logic              cmd_start;
    logic              cmd_stop;
    logic [CNT_W-1:0]  cfg_word_limit;
    logic              fifo_full;
    logic              fifo_rst;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_din;
    logic [CNT_W-1:0]  word_count;
    logic [CNT_W-1:0]  drop_count;
    logic [1:0]        state;
    logic              busy;

    stream_capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH)) dut (
        .ti_clk(ti_clk), .reset(reset), .serial_in(serial_in),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cfg_word_limit(cfg_word_limit),
        .fifo_full(fifo_full), .fifo_rst(fifo_rst), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .word_count(word_count), .drop_count(drop_count),
        .state(state), .busy(busy)
    );

    always #5 ti_clk = ~ti_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 flush, 2 capture, 3 done, 4 hunt.
    int          m_phase, m_flush_left, m_limit, m_wc, m_dc;
    bit          m_stop_seen, m_we, m_fr;
    logic [15:0] m_din, m_window, m_w;
    bit          m_bits[$];

    always @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_flush_left = 0; m_limit = 0; m_wc = 0; m_dc = 0;
            m_stop_seen = 0; m_we = 0; m_fr = 0; m_din = '0; m_window = '0;
            m_bits.delete();
        end else begin
            m_we = 0;
            case (m_phase)
                0, 3: if (cmd_start) begin
                    m_phase = 1; m_flush_left = FLUSH; m_fr = 1;
                    m_wc = 0; m_dc = 0; m_limit = cfg_word_limit; m_stop_seen = 0;
                end
                1: begin
                    m_flush_left--;
                    if (cmd_stop) m_stop_seen = 1;
                    if (m_flush_left == 0) begin
                        m_fr = 0; m_bits.delete(); m_window = '0;
`ifdef STREAM_SYNC_HUNT_EN
                        m_phase = m_stop_seen ? 3 : 4;
`else
                        m_phase = m_stop_seen ? 3 : 2;
`endif
                    end
                end
                2: begin
                    m_bits.push_back(serial_in);
                    if (m_bits.size() == DATA_W) begin
                        m_w = '0;
                        for (int i = 0; i < DATA_W; i++) m_w = {m_w[14:0], m_bits[i]};
                        m_bits.delete();
                        if (fifo_full) begin
                            if (m_dc < MAXC) m_dc++;
                        end else begin
                            m_we = 1; m_din = m_w;
                            if (m_wc < MAXC) m_wc++;
                            if (m_limit != 0 && m_wc == m_limit) m_phase = 3;
                        end
                    end
                    if (cmd_stop) begin m_phase = 3; m_bits.delete(); end
                end
                4: begin
                    m_window = {m_window[14:0], serial_in};
                    if (cmd_stop) m_phase = 3;
                    else if (m_window == 16'hA55A) begin m_phase = 2; m_bits.delete(); end
                end
                default: m_phase = 0;
            endcase
        end
    end

    int          cyc = 0;
    int          rst_cnt = 0;
    logic [15:0] got[$];
    int          wr_cyc[$];

    always @(posedge ti_clk) cyc++;

    always @(negedge ti_clk) begin
        check("state", state, (m_phase == 4) ? 2 : m_phase);
        check("busy", busy, (m_phase == 1 || m_phase == 2 || m_phase == 4));
        check("fifo_rst", fifo_rst, m_fr);
        check("fifo_wr_en", fifo_wr_en, m_we);
        check("word_count", word_count, m_wc);
        check("drop_count", drop_count, m_dc);
        if (m_we) check("fifo_din", fifo_din, m_din);
        check("rst_wr_excl", fifo_rst & fifo_wr_en, 0);
        if (fifo_wr_en) begin got.push_back(fifo_din); wr_cyc.push_back(cyc); end
        if (fifo_rst) rst_cnt++;
    end

    function automatic logic [31:0] got_at(input int i);
        return (i < got.size()) ? {16'h0, got[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic step();
        @(posedge ti_clk);
        #2;
    endtask

    task automatic clear_log();
        got.delete(); wr_cyc.delete(); rst_cnt = 0;
    endtask

    task automatic start_cap(input int lim);
        cfg_word_limit = CNT_W'(lim);
        cmd_start = 1'b1; step();
        cmd_start = 1'b0;
        cfg_word_limit = '1;  // later changes must not affect the latched limit
        repeat (FLUSH) step();
    endtask

    task automatic send_bits(input logic [15:0] w, input int n, input logic full);
        for (int i = 15; i > 15 - n; i--) begin
            serial_in = w[i];
            fifo_full = full;
            step();
        end
        fifo_full = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input logic full);
        send_bits(w, 16, full);
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; serial_in = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
        cfg_word_limit = '0; fifo_full = 1'b0;
        repeat (3) step();
        check("reset_state", state, 0);
        check("reset_wr_en", fifo_wr_en, 0);
        reset = 1'b0;
        step();

`ifdef STREAM_SYNC_HUNT_EN
        clear_log();
        start_cap(0);
        send_word(16'h0000, 1'b0);
        send_word(16'hA55A, 1'b0);
        send_word(16'h0001, 1'b0);
        repeat (2) step();
        check("hunt_writes", got.size(), 1);
        check("hunt_first", got_at(0), 32'h0001);
        pulse_stop(); step();
`else
        // limit 3: three writes 16 cycles apart, fourth word ignored
        clear_log();
        start_cap(3);
        send_word(16'h1234, 1'b0);
        send_word(16'hABCD, 1'b0);
        send_word(16'h0F0F, 1'b0);
        send_word(16'hFFFF, 1'b0);
        repeat (2) step();
        check("t2_rst_cycles", rst_cnt, 8);
        check("t2_writes", got.size(), 3);
        check("t2_w0", got_at(0), 32'h1234);
        check("t2_w1", got_at(1), 32'hABCD);
        check("t2_w2", got_at(2), 32'h0F0F);
        check("t2_gap", (wr_cyc.size() == 3) ? wr_cyc[2] - wr_cyc[1] : -1, 16);
        check("t2_state", state, 3);
        check("t2_count", word_count, 3);

        // fifo_full on second word boundary
        clear_log();
        start_cap(0);
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b1);
        send_word(16'h3333, 1'b0);
        pulse_stop(); step();
        check("t3_writes", got.size(), 2);
        check("t3_w0", got_at(0), 32'h1111);
        check("t3_w1", got_at(1), 32'h3333);
        check("t3_drop", drop_count, 1);
        check("t3_count", word_count, 2);

        // stop 5 bits into word 4
        clear_log();
        start_cap(0);
        send_word(16'hC001, 1'b0);
        send_word(16'hC002, 1'b0);
        send_word(16'hC003, 1'b0);
        send_bits(16'hFFFF, 5, 1'b0);
        pulse_stop();
        repeat (20) step();
        check("t4_writes", got.size(), 3);
        check("t4_count", word_count, 3);
        check("t4_state", state, 3);

        // start and stop together in CAPTURE
        start_cap(0);
        send_bits(16'hFFFF, 3, 1'b0);
        cmd_start = 1'b1; cmd_stop = 1'b1; step();
        cmd_start = 1'b0; cmd_stop = 1'b0; step();
        check("t4_startstop", state, 3);

        // stop during flush ends in DONE once flush completes
        clear_log();
        cmd_start = 1'b1; step(); cmd_start = 1'b0; step();
        pulse_stop();
        repeat (FLUSH) step();
        check("flush_stop_state", state, 3);
        check("flush_stop_rst", rst_cnt, 8);

        // saturation with fifo_full stuck
        clear_log();
        start_cap(0);
        for (int k = 0; k < MAXC + 3; k++) send_word(16'h5A5A, 1'b1);
        step();
        check("t5_drop", drop_count, MAXC);
        check("t5_count", word_count, 0);
        check("t5_writes", got.size(), 0);
        pulse_stop(); step();
`endif

        // async reset mid-capture, right after a write
        start_cap(0);
        send_word(16'h8001, 1'b0);
        send_word(16'h8002, 1'b0);
        reset = 1'b1;
        #1;
        check("t1_state", state, 0);
        check("t1_count", word_count, 0);
        check("t1_drop", drop_count, 0);
        check("t1_wr_en", fifo_wr_en, 0);
        check("t1_rst", fifo_rst, 0);
        step();
        reset = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
